// File: rtl/ahb_slave_mux_n_if.sv
// Bus bundle for ahb_slave_mux_n: master request, per-port slave responses
// and the muxed response returned to the master.
interface ahb_slave_mux_n_if #(
  parameter int NPORT = 10,
  parameter int DW    = 32
);
  logic                HREADY;
  logic [1:0]          HTRANS;
  logic [NPORT-1:0]    HSEL;
  logic [NPORT-1:0]    HREADYOUT_S;
  logic [NPORT-1:0]    HRESP_S;
  logic [NPORT*DW-1:0] HRDATA_S;
  logic                HREADYOUT;
  logic                HRESP;
  logic [DW-1:0]       HRDATA;
  logic                MUX_ERR;

  modport master (
    output HREADY, HTRANS, HSEL, HREADYOUT_S, HRESP_S, HRDATA_S,
    input  HREADYOUT, HRESP, HRDATA, MUX_ERR
  );

  modport slave (
    input  HREADY, HTRANS, HSEL, HREADYOUT_S, HRESP_S, HRDATA_S,
    output HREADYOUT, HRESP, HRDATA, MUX_ERR
  );
endinterface

// File: rtl/ahb_slave_mux_n.sv
// AHB slave response multiplexer with built-in default (error) slave.
// Optional wait-state watchdog enabled by macro AHB_SLAVE_MUX_TIMEOUT_EN.
module ahb_slave_mux_n #(
  parameter int               NPORT   = 10,
  parameter int               DW      = 32,
  parameter logic [NPORT-1:0] PORT_EN = '1,
  parameter int               TIMEOUT = 256
) (
  input logic              HCLK,
  input logic              HRESET,
  ahb_slave_mux_n_if.slave bus
);
  typedef enum logic [2:0] {IDLE, ERR1, ERR2, TO1, TO2} state_t;

  state_t           state_q;
  logic [NPORT-1:0] sel_q;
  logic [NPORT-1:0] req_masked;
  logic [NPORT-1:0] req_onehot;
  logic             xfer_active;
  logic             unmapped;
  logic             sel_rdy;
  logic             sel_resp;
  logic             timed_out;
  logic [DW-1:0]    rdata_mux;
  logic [DW-1:0]    rdata_term [NPORT];

  if (NPORT < 1 || NPORT > 16 || TIMEOUT < 2 || TIMEOUT > 65535) begin : g_bad_cfg
    $error("ahb_slave_mux_n: NPORT or TIMEOUT out of range");
  end

  // Lowest set bit of the enabled request wins.
  assign req_masked  = bus.HSEL & PORT_EN;
  assign req_onehot  = req_masked & (~req_masked + NPORT'(1));
  assign xfer_active = (bus.HTRANS == 2'b10) || (bus.HTRANS == 2'b11);
  assign unmapped    = bus.HREADY && xfer_active && (req_masked == '0);

  for (genvar gi = 0; gi < NPORT; gi++) begin : g_port
    assign rdata_term[gi] = bus.HRDATA_S[gi*DW +: DW] & {DW{sel_q[gi]}};
  end

  always_comb begin
    rdata_mux = '0;
    for (int i = 0; i < NPORT; i++) begin
      rdata_mux = rdata_mux | rdata_term[i];
    end
  end

  assign sel_rdy  = |(sel_q & bus.HREADYOUT_S);
  assign sel_resp = |(sel_q & bus.HRESP_S);

`ifdef AHB_SLAVE_MUX_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);
  logic [15:0] wait_cnt_q;
  logic        stalled;

  assign stalled   = (state_q == IDLE) && (|sel_q) && !sel_rdy;
  assign timed_out = stalled && (wait_cnt_q == TO_LAST);

  always_ff @(posedge HCLK) begin
    if (HRESET || !stalled || timed_out) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_q + 16'd1;
    end
  end
`else
  assign timed_out = 1'b0;
`endif

  // Leaving IDLE always drops the slave selection so a late slave cannot leak through.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q <= IDLE;
      sel_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (unmapped) begin
            state_q <= ERR1;
            sel_q   <= '0;
          end else if (timed_out) begin
            state_q <= TO1;
            sel_q   <= '0;
          end else if (bus.HREADY) begin
            sel_q <= req_onehot;
          end
        end
        ERR1: state_q <= ERR2;
        TO1:  state_q <= TO2;
        ERR2, TO2: begin
          if (unmapped) begin
            state_q <= ERR1;
          end else begin
            state_q <= IDLE;
            if (bus.HREADY) begin
              sel_q <= req_onehot;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          sel_q   <= '0;
        end
      endcase
    end
  end

  always_comb begin
    bus.HREADYOUT = 1'b1;
    bus.HRESP     = 1'b0;
    bus.HRDATA    = '0;
    case (state_q)
      IDLE: begin
        if (|sel_q) begin
          bus.HREADYOUT = sel_rdy;
          bus.HRESP     = sel_resp;
          bus.HRDATA    = rdata_mux;
        end
      end
      ERR1, TO1: begin
        bus.HREADYOUT = 1'b0;
        bus.HRESP     = 1'b1;
      end
      ERR2, TO2: begin
        bus.HRESP = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.MUX_ERR = (state_q == ERR1) || (state_q == TO1);

endmodule

// File: tb/tb_ahb_slave_mux_n.sv
// Scoreboard bench for ahb_slave_mux_n: a transaction-level model predicts each
// cycle's response, a negedge monitor compares it with the DUT.
module tb_ahb_slave_mux_n;
  localparam int         NP      = 10;
  localparam logic [9:0] PEN     = 10'h3FE;
  localparam int         TO_CYC  = 4;

  localparam int K_NONE  = 0;
  localparam int K_SLAVE = 1;
  localparam int K_ERR1  = 2;
  localparam int K_ERR2  = 3;
  localparam int K_TO1   = 4;
  localparam int K_TO2   = 5;

  typedef struct {
    logic        rdy;
    logic        resp;
    logic [31:0] data;
    logic        err;
    int          cyc;
    int          txn;
  } exp_t;

  logic HCLK = 1'b0;
  logic HRESET = 1'b1;

  ahb_slave_mux_n_if #(.NPORT(NP), .DW(32)) bus ();

  ahb_slave_mux_n #(
    .NPORT(NP), .DW(32), .PORT_EN(PEN), .TIMEOUT(TO_CYC)
  ) dut (
    .HCLK(HCLK),
    .HRESET(HRESET),
    .bus(bus)
  );

  // The master and all slaves see the muxed ready, as in a real AHB fabric.
  assign bus.HREADY = bus.HREADYOUT;

  always #5 HCLK = ~HCLK;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_err    = 0;
  int   cyc      = 0;
  int   txn      = 0;

  // Reference model: what is currently in the data phase.
  int          dp_kind  = K_NONE;
  int          dp_port  = 0;
  int          dp_left  = 0;
  int          dp_seen  = 0;
  logic [31:0] dp_data  = '0;
  logic        dp_resp  = 1'b0;

  function automatic logic model_ready();
    case (dp_kind)
      K_SLAVE:      return (dp_left == 0);
      K_ERR1, K_TO1: return 1'b0;
      default:      return 1'b1;
    endcase
  endfunction

  task automatic one_cycle(input logic [9:0] hsel, input logic [1:0] htrans,
                           input int waits, input logic [31:0] data,
                           input logic resp, input logic rst);
    exp_t       e;
    logic [9:0] masked;
    int         p;
    e.rdy = 1'b1; e.resp = 1'b0; e.data = '0; e.err = 1'b0;
    case (dp_kind)
      K_SLAVE: begin
        e.rdy = (dp_left == 0); e.resp = dp_resp; e.data = dp_data;
      end
      K_ERR1, K_TO1: begin e.rdy = 1'b0; e.resp = 1'b1; e.err = 1'b1; end
      K_ERR2, K_TO2: begin e.resp = 1'b1; end
      default: ;
    endcase
    e.cyc = cyc;
    e.txn = txn;
    for (int i = 0; i < NP; i++) begin
      bus.HREADYOUT_S[i]       = 1'($urandom);
      bus.HRESP_S[i]           = 1'($urandom);
      bus.HRDATA_S[i*32 +: 32] = $urandom;
    end
    if (dp_kind == K_SLAVE) begin
      bus.HREADYOUT_S[dp_port]       = (dp_left == 0);
      bus.HRESP_S[dp_port]           = dp_resp;
      bus.HRDATA_S[dp_port*32 +: 32] = dp_data;
    end
    bus.HSEL   = hsel;
    bus.HTRANS = htrans;
    HRESET     = rst;
    exp_q.push_back(e);

    if (rst) begin
      dp_kind = K_NONE;
    end else if (e.rdy) begin
      masked = hsel & PEN;
      txn++;
      if (masked != 0) begin
        p = 0;
        for (int i = NP - 1; i >= 0; i--) if (masked[i]) p = i;
        dp_kind = K_SLAVE;
        dp_port = p;
        dp_left = htrans[1] ? waits : 0;
        dp_resp = htrans[1] ? resp : 1'b0;
        dp_data = data;
        dp_seen = 0;
        $display("txn %0d: hsel=%03h htrans=%0d -> port %0d waits=%0d data=%08h",
                 txn, hsel, htrans, p, dp_left, data);
      end else if (htrans[1]) begin
        dp_kind = K_ERR1;
        $display("txn %0d: hsel=%03h htrans=%0d -> default slave error", txn, hsel, htrans);
      end else begin
        dp_kind = K_NONE;
        $display("txn %0d: hsel=%03h htrans=%0d -> no data phase", txn, hsel, htrans);
      end
    end else begin
      case (dp_kind)
        K_SLAVE: begin
          dp_left--;
          dp_seen++;
`ifdef AHB_SLAVE_MUX_TIMEOUT_EN
          if (dp_seen == TO_CYC) dp_kind = K_TO1;
`endif
        end
        K_ERR1: dp_kind = K_ERR2;
        K_TO1:  dp_kind = K_TO2;
        default: ;
      endcase
    end
    @(posedge HCLK);
    #1;
    cyc++;
  endtask

  task automatic issue(input logic [9:0] hsel, input logic [1:0] htrans,
                       input int waits, input logic [31:0] data, input logic resp);
    int guard = 0;
    while (!model_ready()) begin
      one_cycle(10'($urandom), 2'($urandom), 0, $urandom, 1'b0, 1'b0);
      guard++;
      if (guard > 200) begin
        n_checks++;
        n_err++;
        $display("FAIL issue_bound: data phase still stalled after %0d cycles, required <= 200", guard);
        break;
      end
    end
    one_cycle(hsel, htrans, waits, data, resp, 1'b0);
  endtask

  function automatic logic [9:0] rand_hsel();
    int r = $urandom_range(0, 3);
    if (r == 0) return 10'h000;
    if (r == 1) return 10'(1 << $urandom_range(0, NP - 1));
    return 10'($urandom);
  endfunction

  always @(negedge HCLK) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (bus.HREADYOUT !== e.rdy || bus.HRESP !== e.resp ||
          bus.HRDATA !== e.data || bus.MUX_ERR !== e.err) begin
        n_err++;
        $display("FAIL resp cyc=%0d txn=%0d: got rdy=%b resp=%b data=%08h err=%b, want rdy=%b resp=%b data=%08h err=%b",
                 e.cyc, e.txn, bus.HREADYOUT, bus.HRESP, bus.HRDATA, bus.MUX_ERR,
                 e.rdy, e.resp, e.data, e.err);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.HSEL = '0; bus.HTRANS = 2'b00;
    bus.HREADYOUT_S = '0; bus.HRESP_S = '0; bus.HRDATA_S = '0;
    HRESET = 1'b1;
    @(posedge HCLK);
    #1;
    // Reset held with garbage address: must not capture anything.
    one_cycle(10'h004, 2'b10, 0, 32'h1111_1111, 1'b0, 1'b1);

    // Mapped read to port 2 with one wait state.
    issue(10'h004, 2'b10, 1, 32'hA5A5_0002, 1'b0);
    issue(10'h000, 2'b00, 0, 32'h0, 1'b0);
    // Unmapped NONSEQ, then unmapped IDLE.
    issue(10'h000, 2'b10, 0, 32'h0, 1'b0);
    issue(10'h000, 2'b00, 0, 32'h0, 1'b0);
    issue(10'h000, 2'b00, 0, 32'h0, 1'b0);
    // Disabled port 0.
    issue(10'h001, 2'b10, 0, 32'hDEAD_0000, 1'b0);
    issue(10'h000, 2'b00, 0, 32'h0, 1'b0);
    // Ports 4 and 5 together: port 4 wins.
    issue(10'h030, 2'b10, 0, 32'h4444_0004, 1'b0);
    // Back-to-back unmapped transfers.
    issue(10'h000, 2'b10, 0, 32'h0, 1'b0);
    issue(10'h000, 2'b11, 0, 32'h0, 1'b0);
    issue(10'h000, 2'b00, 0, 32'h0, 1'b0);
    issue(10'h000, 2'b00, 0, 32'h0, 1'b0);
    // Long stall on port 3: times out only when the watchdog is built.
    issue(10'h008, 2'b10, 100, 32'h3333_0003, 1'b0);
    issue(10'h000, 2'b00, 0, 32'h0, 1'b0);
    issue(10'h000, 2'b00, 0, 32'h0, 1'b0);
    // Reset in the middle of an error response, then a normal read.
    issue(10'h000, 2'b10, 0, 32'h0, 1'b0);
    one_cycle(10'($urandom), 2'b10, 0, $urandom, 1'b0, 1'b1);
    issue(10'h080, 2'b10, 2, 32'h7777_0007, 1'b0);
    issue(10'h000, 2'b00, 0, 32'h0, 1'b0);

    for (int n = 0; n < 300; n++) begin
      issue(rand_hsel(), 2'($urandom), $urandom_range(0, 3), $urandom, 1'($urandom));
    end
    issue(10'h000, 2'b00, 0, 32'h0, 1'b0);
    issue(10'h000, 2'b00, 0, 32'h0, 1'b0);

    n_checks++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
